// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: state codes,
// opcodes and the datapath select encodings the controller drives.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_BNE    = 4'd9,
        S_JUMP   = 4'd10,
        S_JAL    = 4'd11,
        S_IEXEC  = 4'd12,
        S_ZEXEC  = 4'd13,
        S_IWB    = 4'd14,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic       ID_PC     = 1'b0;
    localparam logic       ID_ALUOUT = 1'b1;

    localparam logic       A1_PC = 1'b0;
    localparam logic       A1_RS = 1'b1;

    localparam logic [1:0] A2_RT   = 2'd0;
    localparam logic [1:0] A2_FOUR = 2'd1;
    localparam logic [1:0] A2_SEXT = 2'd2;
    localparam logic [1:0] A2_ZEXT = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_OR    = 2'd3;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] RFD_RT  = 2'd0;
    localparam logic [1:0] RFD_RD  = 2'd1;
    localparam logic [1:0] RFD_R31 = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

endpackage

// File: rtl/mc_main_controller_v2.sv
// Multicycle MIPS main controller with memory wait states and illegal-opcode trap.
// Outputs decode the registered state, with mem_ready gating the memory-side enables.
module mc_main_controller_v2
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPW     = 6,
    parameter int unsigned SW      = 4,
    parameter bit          WAIT_EN = 1'b1,
    parameter bit          TRAP_EN = 1'b1
) (
    input  logic           CLK,
    input  logic           rst,
    input  logic [OPW-1:0] op,
    input  logic           mem_ready,
    output logic           IDSel,
    output logic           MWE,
    output logic           IRWE,
    output logic [1:0]     RFDSel,
    output logic [1:0]     MtoRFSel,
    output logic           RFWE,
    output logic           ALUIn1Sel,
    output logic [1:0]     ALUIn2Sel,
    output logic [1:0]     ALUop,
    output logic [1:0]     PCSel,
    output logic           Branch,
    output logic           BranchNE,
    output logic           PCWE,
    output logic           illegal,
    output logic [SW-1:0]  st
);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] opc;
    logic       mem_go;

    assign opc    = 6'(op);
    assign mem_go = WAIT_EN ? mem_ready : 1'b1;
    assign st     = SW'(state_q);

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        IDSel     = ID_PC;
        MWE       = 1'b0;
        IRWE      = 1'b0;
        RFDSel    = RFD_RT;
        MtoRFSel  = M2R_ALUOUT;
        RFWE      = 1'b0;
        ALUIn1Sel = A1_PC;
        ALUIn2Sel = A2_RT;
        ALUop     = ALU_ADD;
        PCSel     = PC_ALU;
        Branch    = 1'b0;
        BranchNE  = 1'b0;
        PCWE      = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            S_FETCH: begin
                ALUIn2Sel = A2_FOUR;
                IRWE      = mem_go;
                PCWE      = mem_go;
                if (mem_go) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUIn2Sel = A2_SEXT;
                case (opc)
                    OP_RTYPE:       state_d = S_REXEC;
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_BEQ:         state_d = S_BEQ;
                    OP_BNE:         state_d = S_BNE;
                    OP_J:           state_d = S_JUMP;
                    OP_JAL:         state_d = S_JAL;
                    OP_ADDI:        state_d = S_IEXEC;
                    OP_ANDI, OP_ORI: state_d = S_ZEXEC;
                    default: begin
                        if (TRAP_EN) begin
                            state_d = S_HALT;
                        end else begin
                            state_d = S_FETCH;
                            illegal = 1'b1;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                ALUIn1Sel = A1_RS;
                ALUIn2Sel = A2_SEXT;
                state_d   = (opc == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IDSel = ID_ALUOUT;
                if (mem_go) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MtoRFSel = M2R_MDR;
                RFWE     = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                IDSel = ID_ALUOUT;
                // a reset arriving with the handshake must not let the store land
                MWE   = mem_go & ~rst;
                if (mem_go) state_d = S_FETCH;
            end
            S_REXEC: begin
                ALUIn1Sel = A1_RS;
                ALUop     = ALU_FUNCT;
                state_d   = S_RWB;
            end
            S_RWB: begin
                RFDSel  = RFD_RD;
                RFWE    = 1'b1;
                state_d = S_FETCH;
            end
            S_BEQ, S_BNE: begin
                ALUIn1Sel = A1_RS;
                ALUop     = ALU_SUB;
                PCSel     = PC_ALUOUT;
                Branch    = (state_q == S_BEQ);
                BranchNE  = (state_q == S_BNE);
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                PCSel   = PC_JUMP;
                PCWE    = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                // r31 captures the already-incremented PC in the same edge the PC jumps
                PCSel    = PC_JUMP;
                PCWE     = 1'b1;
                RFDSel   = RFD_R31;
                MtoRFSel = M2R_PC;
                RFWE     = 1'b1;
                state_d  = S_FETCH;
            end
            S_IEXEC: begin
                ALUIn1Sel = A1_RS;
                ALUIn2Sel = A2_SEXT;
                state_d   = S_IWB;
            end
            S_ZEXEC: begin
                // andi routes through the funct path so the ALU decoder picks AND from op
                ALUIn1Sel = A1_RS;
                ALUIn2Sel = A2_ZEXT;
                ALUop     = (opc == OP_ANDI) ? ALU_FUNCT : ALU_OR;
                state_d   = S_IWB;
            end
            S_IWB: begin
                RFWE    = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_main_controller_v2.sv
// Bench for mc_main_controller_v2: three parameterisations driven in lockstep,
// checked every cycle against an instruction-path model plus literal spot checks.
module tb_mc_main_controller_v2;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_JAL  = 6'b000011;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_ANDI = 6'b001100;
    localparam logic [5:0] T_ORI  = 6'b001101;
    localparam logic [5:0] T_BAD  = 6'b111111;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = T_LW;
    logic       mem_ready = 1'b1;
    bit         chk_en = 1'b0;
    int         checks = 0;
    int         failures = 0;

    always #5 CLK = ~CLK;

    // instance 0: defaults; 1: TRAP_EN=0; 2: WAIT_EN=0
    logic [2:0]      idsel_w, mwe_w, irwe_w, rfwe_w, a1_w, br_w, bne_w, pcwe_w, ill_w;
    logic [1:0]      rfdsel_w [3];
    logic [1:0]      mtorf_w  [3];
    logic [1:0]      a2_w     [3];
    logic [1:0]      aluop_w  [3];
    logic [1:0]      pcsel_w  [3];
    logic [3:0]      st_w     [3];
    logic [2:0][18:0] act;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            mc_main_controller_v2 #(
                .OPW(6), .SW(4), .WAIT_EN(gi != 2), .TRAP_EN(gi != 1)
            ) dut (
                .CLK(CLK), .rst(rst), .op(op), .mem_ready(mem_ready),
                .IDSel(idsel_w[gi]), .MWE(mwe_w[gi]), .IRWE(irwe_w[gi]),
                .RFDSel(rfdsel_w[gi]), .MtoRFSel(mtorf_w[gi]), .RFWE(rfwe_w[gi]),
                .ALUIn1Sel(a1_w[gi]), .ALUIn2Sel(a2_w[gi]), .ALUop(aluop_w[gi]),
                .PCSel(pcsel_w[gi]), .Branch(br_w[gi]), .BranchNE(bne_w[gi]),
                .PCWE(pcwe_w[gi]), .illegal(ill_w[gi]), .st(st_w[gi])
            );
            assign act[gi] = {idsel_w[gi], mwe_w[gi], irwe_w[gi], rfdsel_w[gi], mtorf_w[gi],
                              rfwe_w[gi], a1_w[gi], a2_w[gi], aluop_w[gi], pcsel_w[gi],
                              br_w[gi], bne_w[gi], pcwe_w[gi], ill_w[gi]};
        end
    endgenerate

    function automatic bit is_legal(logic [5:0] o);
        return o inside {T_R, T_LW, T_SW, T_BEQ, T_BNE, T_J, T_JAL, T_ADDI, T_ANDI, T_ORI};
    endfunction

    // Expected select/enable word for a state, straight from the per-state output table.
    function automatic logic [18:0] exp_vec(int s, logic [5:0] o, logic mr, logic r, bit trap);
        logic idsel, mwe, irwe, rfwe, a1, br, bne, pcwe, ill;
        logic [1:0] rfd, mtr, a2, aop, pcs;
        {idsel, mwe, irwe, rfwe, a1, br, bne, pcwe, ill} = '0;
        {rfd, mtr, a2, aop, pcs} = '0;
        case (s)
            0:  begin a2 = 2'd1; irwe = mr; pcwe = mr; end
            1:  begin a2 = 2'd2; ill = !is_legal(o) && !trap; end
            2:  begin a1 = 1'b1; a2 = 2'd2; end
            3:  idsel = 1'b1;
            4:  begin mtr = 2'd1; rfwe = 1'b1; end
            5:  begin idsel = 1'b1; mwe = mr && !r; end
            6:  begin a1 = 1'b1; aop = 2'd2; end
            7:  begin rfd = 2'd1; rfwe = 1'b1; end
            8:  begin a1 = 1'b1; aop = 2'd1; pcs = 2'd1; br = 1'b1; end
            9:  begin a1 = 1'b1; aop = 2'd1; pcs = 2'd1; bne = 1'b1; end
            10: begin pcs = 2'd2; pcwe = 1'b1; end
            11: begin pcs = 2'd2; pcwe = 1'b1; rfd = 2'd2; mtr = 2'd2; rfwe = 1'b1; end
            12: begin a1 = 1'b1; a2 = 2'd2; end
            13: begin a1 = 1'b1; a2 = 2'd3; aop = (o == T_ANDI) ? 2'd2 : 2'd3; end
            14: rfwe = 1'b1;
            default: ill = 1'b1;
        endcase
        return {idsel, mwe, irwe, rfd, mtr, rfwe, a1, a2, aop, pcs, br, bne, pcwe, ill};
    endfunction

    // Model: each instruction is a list of remaining steps; memory steps stall on !mem_ready.
    int m_st   [3];
    int m_path [3][4];
    int m_len  [3];
    int m_pos  [3];

    task automatic push(int i, int v);
        m_path[i][m_len[i]] = v;
        m_len[i]++;
    endtask

    task automatic advance(int i);
        if (m_pos[i] < m_len[i]) begin
            m_st[i] = m_path[i][m_pos[i]];
            m_pos[i]++;
        end else begin
            m_st[i] = 0;
        end
    endtask

    always @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            logic mr;
            mr = (i == 2) ? 1'b1 : mem_ready;
            if (rst) begin
                m_st[i] = 0; m_len[i] = 0; m_pos[i] = 0;
            end else if (m_st[i] == 0) begin
                if (mr) m_st[i] = 1;
            end else if (m_st[i] == 1) begin
                m_len[i] = 0; m_pos[i] = 0;
                case (op)
                    T_LW, T_SW:     push(i, 2);
                    T_R:            begin push(i, 6); push(i, 7); end
                    T_BEQ:          push(i, 8);
                    T_BNE:          push(i, 9);
                    T_J:            push(i, 10);
                    T_JAL:          push(i, 11);
                    T_ADDI:         begin push(i, 12); push(i, 14); end
                    T_ANDI, T_ORI:  begin push(i, 13); push(i, 14); end
                    default:        if (i != 1) push(i, 15);
                endcase
                advance(i);
            end else if (m_st[i] == 2) begin
                m_len[i] = 0; m_pos[i] = 0;
                if (op == T_SW) push(i, 5);
                else begin push(i, 3); push(i, 4); end
                advance(i);
            end else if (m_st[i] == 3 || m_st[i] == 5) begin
                if (mr) advance(i);
            end else if (m_st[i] != 15) begin
                advance(i);
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                logic [18:0] e;
                e = exp_vec(m_st[i], op, (i == 2) ? 1'b1 : mem_ready, rst, i != 1);
                checks++;
                if (act[i] !== e) begin
                    failures++;
                    $display("FAIL model_outputs inst=%0d st=%0d actual=%b required=%b at %0t",
                             i, m_st[i], act[i], e, $time);
                end
                checks++;
                if (st_w[i] !== 4'(m_st[i])) begin
                    failures++;
                    $display("FAIL model_state inst=%0d actual=%0d required=%0d at %0t",
                             i, st_w[i], m_st[i], $time);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, a, e, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_latency(string name, logic [5:0] o, int lat);
        int cnt;
        op = o;
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (st_w[0] != 4'd0 && cnt < 20);
        chk(name, cnt, lat);
        $display("op=%b latency=%0d", o, cnt);
    endtask

    initial begin
        int seq1[6];
        int nm, n5;
        seq1 = '{0, 1, 2, 3, 4, 0};

        cyc();
        chk_en = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) chk("reset_st", st_w[i], 0);
        rst = 1'b0;

        // lw without waits
        for (int k = 0; k < 6; k++) begin
            chk("lw_st", st_w[0], seq1[k]);
            chk("lw_rfwe", rfwe_w[0], (k == 4) ? 1 : 0);
            if (k == 4) chk("lw_mtorf", mtorf_w[0], 1);
            if (k < 5) cyc();
        end
        $display("lw sequence done");

        // sw with 3 wait cycles in MEMWR
        op = T_SW;
        cyc(); cyc(); cyc();
        mem_ready = 1'b0;
        #1;
        nm = 0; n5 = 0;
        for (int k = 0; k < 3; k++) begin
            if (st_w[0] == 4'd5) n5++;
            if (mwe_w[0]) nm++;
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        if (st_w[0] == 4'd5) n5++;
        if (mwe_w[0]) nm++;
        cyc();
        chk("sw_mwe_once", nm, 1);
        chk("sw_st5_cycles", n5, 4);
        chk("sw_back_fetch", st_w[0], 0);
        $display("sw with waits: mwe_pulses=%0d st5_cycles=%0d", nm, n5);

        // fetch stall then bne
        op = T_BNE;
        mem_ready = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("fetch_stall_irwe", irwe_w[0], 0);
            chk("fetch_stall_pcwe", pcwe_w[0], 0);
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        chk("fetch_irwe", irwe_w[0], 1);
        chk("fetch_pcwe", pcwe_w[0], 1);
        cyc();
        chk("bne_decode", st_w[0], 1);
        cyc();
        chk("bne_st", st_w[0], 9);
        chk("bne_branchne", bne_w[0], 1);
        chk("bne_aluop", aluop_w[0], 1);
        chk("bne_pcsel", pcsel_w[0], 1);
        chk("bne_branch", br_w[0], 0);
        cyc();
        $display("bne done st=%0d", st_w[0]);

        // jal and ori
        op = T_JAL;
        cyc(); cyc();
        chk("jal_st", st_w[0], 11);
        chk("jal_pcwe", pcwe_w[0], 1);
        chk("jal_rfwe", rfwe_w[0], 1);
        chk("jal_rfdsel", rfdsel_w[0], 2);
        chk("jal_mtorf", mtorf_w[0], 2);
        cyc();
        op = T_ORI;
        cyc(); cyc();
        chk("ori_st", st_w[0], 13);
        chk("ori_alu2", a2_w[0], 3);
        chk("ori_aluop", aluop_w[0], 3);
        cyc();
        chk("ori_iwb_rfwe", rfwe_w[0], 1);
        cyc();
        $display("jal/ori done st=%0d", st_w[0]);

        // latencies per instruction class
        run_latency("lat_r", T_R, 4);
        run_latency("lat_beq", T_BEQ, 3);
        run_latency("lat_j", T_J, 3);
        run_latency("lat_addi", T_ADDI, 4);
        run_latency("lat_andi", T_ANDI, 4);
        run_latency("lat_sw", T_SW, 4);
        run_latency("lat_lw", T_LW, 5);

        // lw with one MEMRD wait; op change in REXEC ignored
        op = T_LW;
        cyc(); cyc(); cyc();
        mem_ready = 1'b0;
        cyc();
        chk("lw_wait_st", st_w[0], 3);
        mem_ready = 1'b1;
        cyc();
        chk("lw_wait_wb", st_w[0], 4);
        cyc();
        op = T_R;
        cyc(); cyc();
        op = T_J;
        cyc();
        chk("rexec_op_ignored", st_w[0], 7);
        cyc();
        $display("lw wait and op-ignore done st=%0d", st_w[0]);

        // illegal opcode
        op = T_BAD;
        cyc();
        #1;
        chk("ill_decode_notrap", ill_w[1], 1);
        chk("ill_decode_trap", ill_w[0], 0);
        cyc();
        chk("ill_halt_st", st_w[0], 15);
        chk("ill_halt_flag", ill_w[0], 1);
        chk("ill_notrap_st", st_w[1], 0);
        chk("ill_notrap_flag", ill_w[1], 0);
        op = T_LW;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("halt_hold", st_w[0], 15);
        end
        rst = 1'b1;
        cyc();
        chk("halt_reset", st_w[0], 0);
        rst = 1'b0;
        $display("illegal trap done");

        // reset during a stalled store
        op = T_SW;
        cyc(); cyc(); cyc();
        mem_ready = 1'b0;
        cyc();
        chk("rst_memwr_st", st_w[0], 5);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rst_memwr_mwe", mwe_w[0], 0);
        cyc();
        chk("rst_memwr_fetch", st_w[0], 0);
        rst = 1'b0;
        cyc(); cyc();
        $display("reset during store done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
